bcd_convert_sequencer: RTL



---
 rtl/bcd_convert_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/bcd_convert_sequencer.sv
// bcd_convert_sequencer
//   Sequential binary-to-BCD scheduler for the 24-game display path. One
//   shared shift-and-add-3 (double-dabble) engine converts the four operand
//   slots in order and packs the results as three BCD digits per slot.
//
// Ports
//   clk            rising-edge system clock
//   rst_n          synchronous, active-low reset
//   num1..num4     binary slot values (slot 0..3), latched when start is accepted
//   valid[3:0]     per-slot enable, latched with the numbers
//   start          request a pass; only accepted in IDLE
//   busy           high from the cycle after acceptance until done
//   done           one-cycle completion pulse
//   numbers[47:0]  slot i at [12i+11:12i] = {hundreds, tens, ones}; FFF = blank
//   ovf[3:0]       slot i value exceeded 999 (result saturated to 999)
//
// Configuration
//   BCD_DOUBLE_BUFFER_EN  when defined, slot results collect in a shadow
//                         register and numbers/ovf update together in the
//                         done cycle; otherwise each slot is published as
//                         soon as it is written.

module bcd_convert_sequencer #(
    parameter int NUM_W  = 10,
    parameter int SHIFTS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NUM_W-1:0] num1,
    input  logic [NUM_W-1:0] num2,
    input  logic [NUM_W-1:0] num3,
    input  logic [NUM_W-1:0] num4,
    input  logic [3:0]       valid,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [47:0]      numbers,
    output logic [3:0]       ovf
);

    localparam int CNT_W = $clog2(SHIFTS);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;

    state_t           state;
    logic [NUM_W-1:0] lat_num [4];
    logic [3:0]       lat_valid;
    logic [1:0]       slot;
    logic [NUM_W-1:0] bin;
    logic [11:0]      bcd;
    logic [11:0]      bcd_adj;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    logic             wr_en;
    logic [11:0]      wr_data;
    logic             wr_ovf;
    logic             finish;
    logic [47:0]      base_nums;
    logic [3:0]       base_ovf;
    logic [47:0]      merged_nums;
    logic [3:0]       merged_ovf;

`ifdef BCD_DOUBLE_BUFFER_EN
    logic [47:0]      shadow_nums;
    logic [3:0]       shadow_ovf;
    assign base_nums = shadow_nums;
    assign base_ovf  = shadow_ovf;
`else
    assign base_nums = numbers;
    assign base_ovf  = ovf;
`endif

    // add-3 correction applied before each shift
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // A slot result is produced either by a skipped LOAD (blank) or a STORE;
    // both paths merge into the same slot field so one write port serves both.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        wr_ovf  = 1'b0;
        case (state)
            LOAD: begin
                if (!lat_valid[slot]) begin
                    wr_en   = 1'b1;
                    wr_data = 12'hFFF;
                end
            end
            STORE: begin
                wr_en   = 1'b1;
                wr_data = sat ? 12'h999 : bcd;
                wr_ovf  = sat;
            end
            default: ;
        endcase
        finish      = wr_en && (slot == 2'd3);
        merged_nums = base_nums;
        merged_ovf  = base_ovf;
        if (wr_en) begin
            merged_nums[12*int'(slot) +: 12] = wr_data;
            merged_ovf[slot]                 = wr_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            numbers   <= '0;
            ovf       <= '0;
            lat_valid <= '0;
            slot      <= '0;
            bin       <= '0;
            bcd       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) lat_num[i] <= '0;
`ifdef BCD_DOUBLE_BUFFER_EN
            shadow_nums <= '0;
            shadow_ovf  <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef BCD_DOUBLE_BUFFER_EN
            if (wr_en) begin
                shadow_nums <= merged_nums;
                shadow_ovf  <= merged_ovf;
            end
            // the last slot's write is folded in so the publish is atomic
            if (finish) begin
                numbers <= merged_nums;
                ovf     <= merged_ovf;
            end
`else
            if (wr_en) begin
                numbers <= merged_nums;
                ovf     <= merged_ovf;
            end
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        lat_num[0] <= num1;
                        lat_num[1] <= num2;
                        lat_num[2] <= num3;
                        lat_num[3] <= num4;
                        lat_valid  <= valid;
                        slot       <= '0;
                        busy       <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (lat_valid[slot]) begin
                        bin   <= lat_num[slot];
                        bcd   <= '0;
                        cnt   <= '0;
                        sat   <= (lat_num[slot] > NUM_W'(999));
                        state <= SHIFT;
                    end else if (finish) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        slot  <= slot + 2'd1;
                    end
                end
                SHIFT: begin
                    bcd <= {bcd_adj[10:0], bin[NUM_W-1]};
                    bin <= {bin[NUM_W-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(SHIFTS - 1))
                        state <= STORE;
                end
                STORE: begin
                    if (finish) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        slot  <= slot + 2'd1;
                        state <= LOAD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
